// File: rtl/sw_key_input_port_if.sv
// Avalon-MM slave bus bundle for the switch/key input port.
// Signals: 2-bit word address, read/write strobes, 32-bit write and read data.
interface sw_key_input_port_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/sw_key_input_port.sv
// Debounced switch/key input port: sync, debounce, edge capture, Avalon-MM regs.
// Ports: clk_clk, reset_reset_n (sync, active-low), pins_in, avs (slave), irq.
// Map: 0 DATA(ro) 1 IRQMASK(rw) 2 EDGECAP(w1c) 3 RAW(ro).
// Define SWIN_IRQ_EN to build IRQMASK and the interrupt; otherwise irq=0.
module sw_key_input_port #(
  parameter int              N_IN            = 12,
  parameter int              DEBOUNCE_CYCLES = 500000,
  parameter int              CNT_W           = 20,
  parameter logic [N_IN-1:0] INIT_VAL        = 12'hF00
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [N_IN-1:0]     pins_in,
  sw_key_input_port_if.slave  avs,
  output logic                irq
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  r_sync1;
  logic [N_IN-1:0]  r_sync2;
  logic [N_IN-1:0]  r_deb;
  logic [N_IN-1:0]  r_edge;
  logic [CNT_W-1:0] r_cnt [N_IN];
  logic [31:0]      r_rdata;

  logic [N_IN-1:0]  w_chg;
  logic [N_IN-1:0]  w_clr;
  logic [N_IN-1:0]  w_mask;
  logic [N_IN-1:0]  w_rd;
  logic             w_wr_mask;
  logic             w_wr_edge;

  // Upper write-data bits have no register behind them.
  wire w_unused = &{1'b0, avs.avs_writedata[31:N_IN]};

  assign w_wr_mask = avs.avs_write && (avs.avs_address == 2'd1);
  assign w_wr_edge = avs.avs_write && (avs.avs_address == 2'd2);
  assign w_clr     = w_wr_edge ? avs.avs_writedata[N_IN-1:0] : '0;

  // A bit is accepted after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    w_chg = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_chg[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == LAST);
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (avs.avs_address)
      2'd0:    w_rd = r_deb;
      2'd1:    w_rd = w_mask;
      2'd2:    w_rd = r_edge;
      default: w_rd = r_sync2;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_sync1 <= INIT_VAL;
      r_sync2 <= INIT_VAL;
      r_deb   <= INIT_VAL;
      r_edge  <= '0;
      r_rdata <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= pins_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_IN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_chg[i]) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      // A change in the same cycle as a clear keeps the bit set.
      r_edge <= (r_edge & ~w_clr) | w_chg;
      if (avs.avs_read) begin
        r_rdata <= 32'(w_rd);
      end
    end
  end

  assign avs.avs_readdata = r_rdata;

`ifdef SWIN_IRQ_EN
  logic [N_IN-1:0] r_mask;
  logic            r_irq;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_mask) begin
        r_mask <= avs.avs_writedata[N_IN-1:0];
      end
      r_irq <= |(r_edge & r_mask);
    end
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  wire w_unused_mask = w_wr_mask;
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

endmodule
